// File: rtl/line_mem_pkg.sv
// Shared types and sizing for the L2 line to narrow memory bridge.
// Line and word geometry are fixed; the beat count derives from them.
package line_mem_pkg;

  localparam int LINE_W = 128;
  localparam int WORD_W = 16;
  localparam int BEATS  = LINE_W / WORD_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE,
    RD_BEAT,
    WR_BEAT,
    DONE
  } state_e;

  typedef enum logic {
    RD,
    WR
  } op_e;

endpackage

// File: rtl/line_mem_bridge.sv
// Serialises 128-bit L2 line requests into eight 16-bit memory beats
// and returns one L2_resp per line unless the requester changed.
module line_mem_bridge
  import line_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              L2_read,
  input  logic              L2_write,
  input  logic [ADDR_W-1:0] L2_addr,
  input  logic [LINE_W-1:0] L2_wdata,
  output logic [LINE_W-1:0] L2_rdata,
  output logic              L2_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int LN_W = ADDR_W - OFF_W;

  state_e            state_q;
  op_e               op_q;
  logic [LN_W-1:0]   line_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] beat_d;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rbuf_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;

  logic [LN_W-1:0]   req_line;
  logic              last_beat;
  logic              op_match;
  logic              unused_addr;

  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [LN_W-1:0]   ln,
    input logic [BEAT_W-1:0] b
  );
    return {ln, b, {(OFF_W-BEAT_W){1'b0}}};
  endfunction

  assign req_line    = L2_addr[ADDR_W-1:OFF_W];
  assign unused_addr = ^L2_addr[OFF_W-1:0];
  assign beat_d      = beat_q + 1'b1;
  assign last_beat   = (beat_q == BEAT_W'(BEATS-1));

  // Response only if the arbiter still presents the same requester.
  assign op_match = (op_q == WR) ? L2_write
                                 : (L2_read & ~L2_write);
  assign L2_resp  = (state_q == DONE) & op_match
                  & (req_line == line_q);

  assign L2_rdata  = rbuf_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= RD;
      line_q      <= '0;
      beat_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          beat_q <= '0;
          priority case (1'b1)
            L2_write: begin
              op_q        <= WR;
              line_q      <= req_line;
              wdata_q     <= L2_wdata;
              mem_write_q <= 1'b1;
              mem_addr_q  <= beat_addr(req_line, '0);
              mem_wdata_q <= L2_wdata[WORD_W-1:0];
              state_q     <= WR_BEAT;
            end
            L2_read: begin
              op_q       <= RD;
              line_q     <= req_line;
              mem_read_q <= 1'b1;
              mem_addr_q <= beat_addr(req_line, '0);
              state_q    <= RD_BEAT;
            end
            default: ;
          endcase
        end
        RD_BEAT: begin
          if (mem_resp) begin
            rbuf_q[int'(beat_q)*WORD_W +: WORD_W] <= mem_rdata;
            if (last_beat) begin
              beat_q     <= '0;
              mem_read_q <= 1'b0;
              state_q    <= DONE;
            end else begin
              beat_q     <= beat_d;
              mem_addr_q <= beat_addr(line_q, beat_d);
            end
          end
        end
        WR_BEAT: begin
          if (mem_resp) begin
            if (last_beat) begin
              beat_q      <= '0;
              mem_write_q <= 1'b0;
              state_q     <= DONE;
            end else begin
              beat_q      <= beat_d;
              mem_addr_q  <= beat_addr(line_q, beat_d);
              mem_wdata_q <= wdata_q[int'(beat_d)*WORD_W +: WORD_W];
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_bridge.sv
// Directed bench for line_mem_bridge with a timeline model of each
// line transaction and a latency-programmable word memory.
module tb_line_mem_bridge;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         L2_read, L2_write, L2_resp;
  logic [15:0]  L2_addr;
  logic [127:0] L2_wdata, L2_rdata;
  logic         mem_read, mem_write, mem_resp;
  logic [15:0]  mem_addr, mem_wdata, mem_rdata;

  int lat = 1;
  logic [15:0] mem [0:32767];

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
  } acc_t;
  acc_t log_q[$];

  int npass = 0;
  int ntot = 0;
  int resp_cnt = 0;
  int rd_cycles = 0;

  logic         m_busy = 1'b0;
  logic         m_wr = 1'b0;
  int           m_cyc = 0;
  int           m_s = 0;
  int           m_n = 1;
  logic [11:0]  m_line = '0;
  logic [127:0] m_wd = '0;
  logic [127:0] m_pend = '0;
  logic [127:0] m_buf = '0;

  localparam logic [127:0] T1_LINE =
    128'hA007_A006_A005_A004_A003_A002_A001_A000;
  localparam logic [127:0] T2_WD =
    128'h7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [127:0] T4_WD =
    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  line_mem_bridge dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .L2_read   (L2_read),
    .L2_write  (L2_write),
    .L2_addr   (L2_addr),
    .L2_wdata  (L2_wdata),
    .L2_rdata  (L2_rdata),
    .L2_resp   (L2_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  initial begin
    for (int i = 0; i < 32768; i++)
      mem[i] = 16'(i * 2) ^ 16'h5A5A;
    for (int i = 0; i < 8; i++)
      mem[{12'h123, 3'(i)}] = 16'hA000 + 16'(i);
  end

  function automatic logic [127:0] line_of(input logic [11:0] ln);
    logic [127:0] r;
    for (int i = 0; i < 8; i++)
      r[16*i +: 16] = mem[{ln, 3'(i)}];
    return r;
  endfunction

  // Memory answers each word request in its lat-th cycle.
  int mcnt = 0;
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_resp = 1'b0;
      mem_rdata = '0;
      mcnt = 0;
    end else if (mem_read || mem_write) begin
      mcnt = mcnt + 1;
      if (mcnt >= lat) begin
        mem_resp = 1'b1;
        mem_rdata = mem[mem_addr[15:1]];
        mcnt = 0;
      end else begin
        mem_resp = 1'b0;
      end
    end else begin
      mem_resp = 1'b0;
      mcnt = 0;
    end
  end

  always @(posedge clk)
    if (reset_n && mem_resp && (mem_read || mem_write))
      log_q.push_back('{mem_write, mem_addr, mem_wdata});

  // Transaction timeline: beats fill cycles 1..8N, response at 8N+1.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_buf  <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_busy) begin
        if (m_cyc - m_s + 1 == 8 * m_n + 1) begin
          m_busy <= 1'b0;
          if (!m_wr) m_buf <= m_pend;
        end
      end else if (L2_read || L2_write) begin
        m_busy <= 1'b1;
        m_s    <= m_cyc + 1;
        m_wr   <= L2_write;
        m_line <= L2_addr[15:4];
        m_wd   <= L2_wdata;
        m_n    <= lat;
        m_pend <= line_of(L2_addr[15:4]);
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    ntot = ntot + 1;
    if (act === exp) npass = npass + 1;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic cmp_loop();
    forever begin
      int c, k;
      logic beat_on, ex_resp;
      logic [15:0] ex_addr;
      @(negedge clk);
      c = m_cyc - m_s + 1;
      beat_on = m_busy && c >= 1 && c <= 8 * m_n;
      k = beat_on ? (c - 1) / m_n : 0;
      ex_resp = m_busy && c == 8 * m_n + 1 &&
                (m_wr ? L2_write : (L2_read && !L2_write)) &&
                L2_addr[15:4] == m_line;
      chk("mem_read", 128'(mem_read), 128'(beat_on && !m_wr));
      chk("mem_write", 128'(mem_write), 128'(beat_on && m_wr));
      chk("L2_resp", 128'(L2_resp), 128'(ex_resp));
      if (beat_on) begin
        ex_addr = {m_line, 4'h0} + 16'(2 * k);
        chk("mem_addr", 128'(mem_addr), 128'(ex_addr));
      end
      if (beat_on && m_wr)
        chk("mem_wdata", 128'(mem_wdata), 128'(m_wd[16*k +: 16]));
      if (!(beat_on && !m_wr))
        chk("L2_rdata", L2_rdata,
            (m_busy && !m_wr) ? m_pend : m_buf);
      if (L2_resp === 1'b1) resp_cnt = resp_cnt + 1;
      if (mem_read === 1'b1) rd_cycles = rd_cycles + 1;
    end
  endtask

  task automatic run_txn(input logic rd, input logic wr,
                         input logic [15:0] a, input logic [127:0] wd,
                         input int n, output int rc);
    lat = n;
    L2_read = rd;
    L2_write = wr;
    L2_addr = a;
    L2_wdata = wd;
    rc = -1;
    @(posedge clk);
    for (int c = 1; c <= 8 * n + 8; c++) begin
      #2;
      if (L2_resp) begin
        rc = c;
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    L2_read = 1'b0;
    L2_write = 1'b0;
  endtask

  initial begin
    int rc, rc2, b, r0, rdc0;
    reset_n = 1'b0;
    L2_read = 1'b0;
    L2_write = 1'b0;
    L2_addr = '0;
    L2_wdata = '0;
    fork
      cmp_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_rdata", L2_rdata, 128'(0));
    chk("rst_resp", 128'(L2_resp), 128'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    b = log_q.size();
    run_txn(1'b1, 1'b0, 16'h1230, '0, 1, rc);
    chk("t1_resp_cycle", 128'(rc), 128'(9));
    chk("t1_rdata", L2_rdata, T1_LINE);
    for (int i = 0; i < 8; i++)
      chk("t1_beat_addr", 128'(log_q[b+i].a), 128'(16'h1230 + 16'(2*i)));

    b = log_q.size();
    run_txn(1'b0, 1'b1, 16'h0040, T2_WD, 3, rc);
    chk("t2_resp_cycle", 128'(rc), 128'(25));
    chk("t2_rdata_kept", L2_rdata, T1_LINE);
    chk("t2_nbeats", 128'(log_q.size() - b), 128'(8));
    for (int i = 0; i < 8; i++) begin
      chk("t2_is_wr", 128'(log_q[b+i].wr), 128'(1));
      chk("t2_addr", 128'(log_q[b+i].a), 128'(16'h0040 + 16'(2*i)));
      chk("t2_data", 128'(log_q[b+i].d), 128'(16'(32'h1111 * i)));
    end

    b = log_q.size();
    lat = 1;
    L2_read = 1'b1;
    L2_addr = 16'h5000;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    L2_addr = 16'h6000;
    repeat (4) @(posedge clk);
    #2;
    chk("t3_done_noresp", 128'(L2_resp), 128'(0));
    rc = -1;
    for (int c = 10; c <= 40; c++) begin
      @(posedge clk);
      #2;
      if (L2_resp) begin
        rc = c;
        break;
      end
    end
    @(posedge clk);
    #1;
    L2_read = 1'b0;
    chk("t3_fresh_resp_cycle", 128'(rc), 128'(19));
    for (int i = 0; i < 8; i++) begin
      chk("t3_old_addr", 128'(log_q[b+i].a), 128'(16'h5000 + 16'(2*i)));
      chk("t3_new_addr", 128'(log_q[b+8+i].a), 128'(16'h6000 + 16'(2*i)));
    end
    chk("t3_rdata", L2_rdata, line_of(12'h600));

    b = log_q.size();
    rdc0 = rd_cycles;
    run_txn(1'b1, 1'b1, 16'h0100, T4_WD, 1, rc);
    chk("t4_resp_cycle", 128'(rc), 128'(9));
    chk("t4_no_mem_read", 128'(rd_cycles - rdc0), 128'(0));
    chk("t4_first_wr", 128'(log_q[b].wr), 128'(1));
    chk("t4_first_data", 128'(log_q[b].d), 128'(16'h3210));
    chk("t4_last_addr", 128'(log_q[b+7].a), 128'(16'h010E));
    chk("t4_last_data", 128'(log_q[b+7].d), 128'(16'h0123));

    lat = 1;
    L2_read = 1'b1;
    L2_addr = 16'h1230;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_beat3_read", 128'(mem_read), 128'(1));
    chk("t5_beat3_addr", 128'(mem_addr), 128'(16'h1236));
    reset_n = 1'b0;
    #1;
    chk("t5_async_read", 128'(mem_read), 128'(0));
    chk("t5_async_resp", 128'(L2_resp), 128'(0));
    L2_read = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("t5_rdata_clr", L2_rdata, 128'(0));
    @(posedge clk);
    #1;
    run_txn(1'b1, 1'b0, 16'h1230, '0, 1, rc);
    chk("t5_after_cycle", 128'(rc), 128'(9));
    chk("t5_after_rdata", L2_rdata, T1_LINE);

    r0 = resp_cnt;
    b = log_q.size();
    run_txn(1'b1, 1'b0, 16'h0010, '0, 1, rc);
    run_txn(1'b1, 1'b0, 16'h0020, '0, 1, rc2);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_first_cycle", 128'(rc), 128'(9));
    chk("t6_second_cycle", 128'(rc2), 128'(9));
    chk("t6_resp_pulses", 128'(resp_cnt - r0), 128'(2));
    chk("t6_beats", 128'(log_q.size() - b), 128'(16));
    chk("t6_second_addr", 128'(log_q[b+8].a), 128'(16'h0020));
    chk("t6_rdata", L2_rdata, line_of(12'h002));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
